// File: rtl/jt6295_pkg.sv
// Shared definitions for the JT6295 ADPCM encoder/decoder: step table, index
// adjustment table and encoder state encoding.
package jt6295_pkg;

  localparam int PCM_W   = 12;
  localparam int NIB_W   = 4;
  localparam int IDX_W   = 6;
  localparam int STEP_W  = 11;
  localparam int IDX_MAX = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B2,
    ST_B1,
    ST_B0,
    ST_UPD
  } enc_state_t;

  function automatic logic [STEP_W-1:0] step_of(input logic [IDX_W-1:0] idx);
    logic [STEP_W-1:0] s;
    case (idx)
      6'd0:  s = 11'd16;   6'd1:  s = 11'd17;   6'd2:  s = 11'd19;   6'd3:  s = 11'd21;
      6'd4:  s = 11'd23;   6'd5:  s = 11'd25;   6'd6:  s = 11'd28;   6'd7:  s = 11'd31;
      6'd8:  s = 11'd34;   6'd9:  s = 11'd37;   6'd10: s = 11'd41;   6'd11: s = 11'd45;
      6'd12: s = 11'd50;   6'd13: s = 11'd55;   6'd14: s = 11'd60;   6'd15: s = 11'd66;
      6'd16: s = 11'd73;   6'd17: s = 11'd80;   6'd18: s = 11'd88;   6'd19: s = 11'd97;
      6'd20: s = 11'd107;  6'd21: s = 11'd118;  6'd22: s = 11'd130;  6'd23: s = 11'd143;
      6'd24: s = 11'd157;  6'd25: s = 11'd173;  6'd26: s = 11'd190;  6'd27: s = 11'd209;
      6'd28: s = 11'd230;  6'd29: s = 11'd253;  6'd30: s = 11'd279;  6'd31: s = 11'd307;
      6'd32: s = 11'd337;  6'd33: s = 11'd371;  6'd34: s = 11'd408;  6'd35: s = 11'd449;
      6'd36: s = 11'd494;  6'd37: s = 11'd544;  6'd38: s = 11'd598;  6'd39: s = 11'd658;
      6'd40: s = 11'd724;  6'd41: s = 11'd796;  6'd42: s = 11'd876;  6'd43: s = 11'd963;
      6'd44: s = 11'd1060; 6'd45: s = 11'd1166; 6'd46: s = 11'd1282; 6'd47: s = 11'd1411;
      default: s = 11'd1552;
    endcase
    return s;
  endfunction

  // Index adjustment keyed by the three magnitude bits of a code.
  function automatic logic signed [4:0] adj_of(input logic [2:0] mag_bits);
    logic signed [4:0] a;
    case (mag_bits)
      3'd4:    a = 5'sd2;
      3'd5:    a = 5'sd4;
      3'd6:    a = 5'sd6;
      3'd7:    a = 5'sd8;
      default: a = -5'sd1;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/jt6295_adpcm_upd.sv
// Combinational predictor update: delta from code, saturating 12-bit add/sub,
// and clamped step-index adjustment. Shared by encoder and decoder.
module jt6295_adpcm_upd
  import jt6295_pkg::*;
(
  input  logic [PCM_W-1:0]  pred,
  input  logic [IDX_W-1:0]  idx,
  input  logic [NIB_W-1:0]  code,
  output logic [PCM_W-1:0]  pred_nx,
  output logic [IDX_W-1:0]  idx_nx,
  output logic [STEP_W-1:0] step
);

  logic [12:0]       delta;
  logic [13:0]       pred_ext;
  logic signed [13:0] sum;
  logic signed [4:0] adj;
  logic signed [7:0] idx_sum;

  // NOTE: every always_comb output gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    step     = step_of(idx);
    delta    = {5'd0, step[10:3]}
             + (code[2] ? {2'd0, step}        : 13'd0)
             + (code[1] ? {3'd0, step[10:1]}  : 13'd0)
             + (code[0] ? {4'd0, step[10:2]}  : 13'd0);
    pred_ext = {{2{pred[11]}}, pred};
    sum      = code[3] ? $signed(pred_ext - {1'b0, delta})
                       : $signed(pred_ext + {1'b0, delta});
    pred_nx  = sum[11:0];
    if (sum > 14'sd2047)       pred_nx = 12'h7ff;
    else if (sum < -14'sd2048) pred_nx = 12'h800;

    adj     = adj_of(code[2:0]);
    idx_sum = $signed({2'b00, idx}) + $signed({{3{adj[4]}}, adj});
    idx_nx  = idx_sum[5:0];
    if (idx_sum < 8'sd0)                   idx_nx = '0;
    else if (idx_sum > 8'(IDX_MAX))        idx_nx = 6'(IDX_MAX);
  end

endmodule

// File: rtl/jt6295_adpcm_enc.sv
// OKI/Dialogic 4-bit ADPCM encoder: one bit of the code resolved per cen cycle,
// predictor and step index mirrored bit-exactly against the JT6295 decoder.
module jt6295_adpcm_enc
  import jt6295_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              clr,
  input  logic [PCM_W-1:0]  pcm_in,
  input  logic              pcm_valid,
  output logic              pcm_ready,
  output logic [NIB_W-1:0]  nib,
  output logic              nib_valid,
  output logic [PCM_W-1:0]  pred
);

  enc_state_t        state, state_nx;
  logic [12:0]       mag;
  logic              sign;
  logic [2:0]        bits;
  logic [IDX_W-1:0]  idx;

  logic [12:0]       diff;
  logic [12:0]       mag_in;
  logic [PCM_W-1:0]  pred_nx;
  logic [IDX_W-1:0]  idx_nx;
  logic [STEP_W-1:0] step;

  jt6295_adpcm_upd u_upd (
    .pred    (pred),
    .idx     (idx),
    .code    ({sign, bits}),
    .pred_nx (pred_nx),
    .idx_nx  (idx_nx),
    .step    (step)
  );

  assign diff      = {pcm_in[11], pcm_in} - {pred[11], pred};
  assign mag_in    = diff[12] ? (~diff + 13'd1) : diff;
  assign pcm_ready = (state == ST_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pcm_valid) state_nx = ST_B2;
      ST_B2:   state_nx = ST_B1;
      ST_B1:   state_nx = ST_B0;
      ST_B0:   state_nx = ST_UPD;
      ST_UPD:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (clr) state_nx = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mag       <= '0;
      sign      <= 1'b0;
      bits      <= '0;
      idx       <= '0;
      pred      <= '0;
      nib       <= '0;
      nib_valid <= 1'b0;
    end else if (cen) begin
      state     <= state_nx;
      nib_valid <= 1'b0;
      if (clr) begin
        pred <= '0;
        idx  <= '0;
      end else begin
        case (state)
          ST_IDLE: if (pcm_valid) begin
            sign <= diff[12];
            mag  <= mag_in;
            bits <= '0;
          end
          ST_B2: if (mag >= {2'd0, step}) begin
            bits[2] <= 1'b1;
            mag     <= mag - {2'd0, step};
          end
          ST_B1: if (mag >= {3'd0, step[10:1]}) begin
            bits[1] <= 1'b1;
            mag     <= mag - {3'd0, step[10:1]};
          end
          ST_B0: bits[0] <= (mag >= {4'd0, step[10:2]});
          ST_UPD: begin
            pred      <= pred_nx;
            idx       <= idx_nx;
            nib       <= {sign, bits};
            nib_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end else begin
      // nib_valid is a single-clk pulse even when cen stays low afterwards.
      nib_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt6295_adpcm_enc.sv
// Directed bench for jt6295_adpcm_enc with a small decoder model for the
// random loopback section.
module tb_jt6295_adpcm_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        clr;
  logic [11:0] pcm_in;
  logic        pcm_valid;
  logic        pcm_ready;
  logic [3:0]  nib;
  logic        nib_valid;
  logic [11:0] pred;

  int checks   = 0;
  int failures = 0;
  int nv_seen  = 0;
  int m_pred, m_idx;

  int step_tab [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
                        107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,
                        494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552};
  int adj_tab [8] = '{-1,-1,-1,-1,2,4,6,8};

  jt6295_adpcm_enc dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .clr       (clr),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .nib       (nib),
    .nib_valid (nib_valid),
    .pred      (pred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cen = 1'b0; clr = 1'b0; pcm_valid = 1'b0; pcm_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cen = 1'b1;
  endtask

  // Present one sample with cen held high; return clk edges from accept to nib_valid.
  task automatic encode(input int sample, output int lat);
    @(negedge clk);
    pcm_in    = 12'(sample);
    pcm_valid = 1'b1;
    @(posedge clk); #1;
    pcm_valid = 1'b0;
    lat = 0;
    while (!nib_valid && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic cen_cycle(input logic c);
    @(negedge clk);
    cen = c;
    @(posedge clk); #1;
    if (nib_valid) nv_seen++;
  endtask

  task automatic model_upd(input int code);
    int st, d;
    st = step_tab[m_idx];
    d  = st / 8;
    if (code & 4) d += st;
    if (code & 2) d += st / 2;
    if (code & 1) d += st / 4;
    m_pred = (code & 8) ? m_pred - d : m_pred + d;
    if (m_pred > 2047)  m_pred = 2047;
    if (m_pred < -2048) m_pred = -2048;
    m_idx = m_idx + adj_tab[code & 7];
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 48) m_idx = 48;
  endtask

  initial begin
    int lat;
    int s;
    int sat_in   [10] = '{2047,2047,2047,2047,2047,2047,2047,-2048,-2048,-2048};
    int sat_nib  [10] = '{7,7,7,7,7,4,0,15,14,8};
    int sat_pred [10] = '{30,93,229,522,1153,1967,2047,555,-1967,-2048};
    int sat_idx  [10] = '{8,16,24,32,40,42,41,48,48,47};

    // Reset state
    do_reset();
    #1;
    check("rst_nib", nib, 0);
    check("rst_nib_valid", nib_valid, 0);
    check("rst_pred", $signed(pred), 0);
    check("rst_pcm_ready", pcm_ready, 1);
    check("rst_idx", dut.idx, 0);

    // Positive step from zero, including latency
    encode(100, lat);
    check("t1_latency", lat, 4);
    check("t1_nib", nib, 7);
    check("t1_pred", $signed(pred), 30);
    check("t1_idx", dut.idx, 8);
    @(posedge clk); #1;
    check("t1_nib_valid_pulse", nib_valid, 0);

    // Negative step, then zero difference
    do_reset();
    encode(-100, lat);
    check("t2a_nib", nib, 15);
    check("t2a_pred", $signed(pred), -30);
    check("t2a_idx", dut.idx, 8);
    encode(-30, lat);
    check("t2b_nib", nib, 0);
    check("t2b_pred", $signed(pred), -26);
    check("t2b_idx", dut.idx, 7);

    // Zero input: predictor still creeps by step>>3, index clamps low
    do_reset();
    encode(0, lat);
    check("t3_nib", nib, 0);
    check("t3_pred", $signed(pred), 2);
    check("t3_idx", dut.idx, 0);

    // Full-scale inputs: predictor saturation and index clamp at 48
    do_reset();
    for (int i = 0; i < 10; i++) begin
      encode(sat_in[i], lat);
      check($sformatf("t4_nib_%0d", i), nib, sat_nib[i]);
      check($sformatf("t4_pred_%0d", i), $signed(pred), sat_pred[i]);
      check($sformatf("t4_idx_%0d", i), dut.idx, sat_idx[i]);
    end

    // Sparse cen, clr while in B1
    do_reset();
    encode(100, lat);
    nv_seen = 0;
    pcm_in = 12'd500; pcm_valid = 1'b1;
    cen_cycle(1'b1);
    pcm_valid = 1'b0;
    check("t5_busy_ready", pcm_ready, 0);
    cen_cycle(1'b0); cen_cycle(1'b0);
    cen_cycle(1'b1);
    cen_cycle(1'b0); cen_cycle(1'b0);
    clr = 1'b1;
    cen_cycle(1'b0);
    check("t5_hold_pred", $signed(pred), 30);
    check("t5_hold_ready", pcm_ready, 0);
    cen_cycle(1'b0);
    cen_cycle(1'b1);
    clr = 1'b0;
    check("t5_clr_pred", $signed(pred), 0);
    check("t5_clr_idx", dut.idx, 0);
    check("t5_clr_ready", pcm_ready, 1);
    check("t5_no_nib_valid", nv_seen, 0);

    // Full encode at 1-in-3 cen cadence gives the same result as full rate
    pcm_in = 12'd100; pcm_valid = 1'b1;
    cen_cycle(1'b1);
    pcm_valid = 1'b0;
    for (int k = 0; k < 30; k++) cen_cycle(k % 3 == 2);
    check("t5_slow_pulses", nv_seen, 1);
    check("t5_slow_nib", nib, 7);
    check("t5_slow_pred", $signed(pred), 30);
    check("t5_slow_idx", dut.idx, 8);
    cen = 1'b1;

    // Random loopback against a decoder model
    do_reset();
    m_pred = 0; m_idx = 0;
    for (int i = 0; i < 400; i++) begin
      s = int'($urandom_range(0, 4095)) - 2048;
      if (i % 50 < 10) s = (i % 2 == 0) ? 2047 : -2048;
      encode(s, lat);
      model_upd(int'(nib));
      check($sformatf("t6_lat_%0d", i), lat, 4);
      check($sformatf("t6_pred_%0d", i), $signed(pred), m_pred);
      check($sformatf("t6_idx_%0d", i), dut.idx, m_idx);
    end

    // Asynchronous reset in the middle of an encode
    @(negedge clk);
    pcm_in = 12'd1000; pcm_valid = 1'b1;
    @(posedge clk); #1;
    pcm_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t7_rst_pred", $signed(pred), 0);
    check("t7_rst_idx", dut.idx, 0);
    check("t7_rst_nib", nib, 0);
    check("t7_rst_ready", pcm_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
